// File: rtl/sr_bank_driver.sv
// Command source for a bank of SR flops: queues requested target words and turns
// each into one cycle of set/reset excitation followed by an optional idle hold.
module sr_bank_driver #(
  parameter int WIDTH  = 4,
  parameter int HOLD_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_target,
  input  logic [HOLD_W-1:0] in_hold,
  output logic [WIDTH-1:0]  s,
  output logic [WIDTH-1:0]  r,
  output logic [WIDTH-1:0]  q_model,
  output logic              busy,
  output logic              word_done,
  output logic [1:0]        dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Handshake: a word is taken on a rising edge where in_valid && in_ready;
  // in_ready is a function of FIFO occupancy only.

  logic [WIDTH-1:0]  tgt_mem_q  [DEPTH];
  logic [HOLD_W-1:0] hold_mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  cur_tgt_q, cur_tgt_d;
  logic [WIDTH-1:0]  q_model_q, q_model_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic [WIDTH-1:0]  r_q, r_d;

  logic              push, pop, fifo_empty, word_end;
  logic [WIDTH-1:0]  head_tgt, base;
  logic [HOLD_W-1:0] head_hold;

  always_comb begin
    fifo_empty = (count_q == '0);
    in_ready   = (count_q != (AW+1)'(DEPTH));
    push       = in_valid && in_ready;
    head_tgt   = tgt_mem_q[rd_ptr_q];
    head_hold  = hold_mem_q[rd_ptr_q];
    // cnt_q holds the word's hold value during APPLY, then counts down in HOLD.
    word_end   = ((state_q == ST_APPLY) && (cnt_q == '0)) ||
                 ((state_q == ST_HOLD) && (cnt_q == HOLD_W'(1)));
    pop        = !fifo_empty && ((state_q == ST_IDLE) || word_end);
    // Back-to-back words must compare against the word being applied now,
    // since q_model only catches up on the edge that ends APPLY.
    base       = (state_q == ST_APPLY) ? cur_tgt_q : q_model_q;

    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_tgt_d = cur_tgt_q;
    q_model_d = q_model_q;
    s_d       = '0;
    r_d       = '0;

    case (state_q)
      ST_APPLY: begin
        q_model_d = cur_tgt_q;
        state_d   = (cnt_q != '0) ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        cnt_d = cnt_q - HOLD_W'(1);
        if (cnt_q == HOLD_W'(1)) state_d = ST_IDLE;
      end
      default: ;
    endcase

    if (pop) begin
      state_d   = ST_APPLY;
      cnt_d     = head_hold;
      cur_tgt_d = head_tgt;
      s_d       = head_tgt & ~base;
      r_d       = ~head_tgt & base;
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cnt_q     <= '0;
      cur_tgt_q <= '0;
      q_model_q <= '0;
      s_q       <= '0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      cur_tgt_q <= cur_tgt_d;
      q_model_q <= q_model_d;
      s_q       <= s_d;
      r_q       <= r_d;
    end
  end

  // Storage needs no reset; occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      tgt_mem_q[wr_ptr_q]  <= in_target;
      hold_mem_q[wr_ptr_q] <= in_hold;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign q_model   = q_model_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign word_done = word_end;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sr_bank_driver.sv
// Bench for sr_bank_driver: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a per-word schedule model.
module tb_sr_bank_driver;

  localparam int W     = 4;
  localparam int HW    = 4;
  localparam int DEPTH = 4;
  localparam int MAXW  = 64;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_target;
  logic [HW-1:0] in_hold;
  logic [W-1:0]  s, r, q_model;
  logic          busy, word_done;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  sr_bank_driver #(.WIDTH(W), .HOLD_W(HW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_target (in_target),
    .in_hold   (in_hold),
    .s         (s),
    .r         (r),
    .q_model   (q_model),
    .busy      (busy),
    .word_done (word_done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(input logic vld, input logic [W-1:0] tgt);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = vld;
    in_target = tgt;
    in_hold   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [W-1:0]  tgt;
    logic [HW-1:0] hold;
    logic [W-1:0]  exp_s;
    logic [W-1:0]  exp_r;
  } vec_t;

  // Send one word to an idle DUT and follow it through APPLY and HOLD.
  task automatic apply_vec(input vec_t v);
    in_valid  = 1'b1;
    in_target = v.tgt;
    in_hold   = v.hold;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("vec_wait_s", s, 0);
    check("vec_busy", busy, 1);
    @(negedge clk);
    check("vec_s", s, v.exp_s);
    check("vec_r", r, v.exp_r);
    check("vec_done_apply", word_done, (v.hold == 0));
    for (int j = 1; j <= int'(v.hold); j++) begin
      @(negedge clk);
      check("vec_hold_sr", {s, r}, 0);
      check("vec_done_hold", word_done, (j == int'(v.hold)));
    end
    @(negedge clk);
    check("vec_q", q_model, v.tgt);
    check("vec_idle_busy", busy, 0);
    check("vec_idle_done", word_done, 0);
  endtask

  // ---------------- reference model ----------------
  // Each accepted word gets a transfer edge, an apply cycle and a final cycle;
  // every output in a cycle follows from that schedule.
  int            m_xfer  [MAXW];
  int            m_apply [MAXW];
  int            m_fin   [MAXW];
  logic [W-1:0]  m_tgt   [MAXW];

  task automatic run_model(input int ncycles, input int valid_pct, input int hmin,
                           input int hmax, input int max_words);
    int n, last_fin, occ, h;
    logic [W-1:0] e_s, e_r, e_q, prev;
    logic e_done, e_act;
    n = 0;
    last_fin = -10;
    for (int k = 0; k < ncycles; k++) begin
      occ = 0; e_s = '0; e_r = '0; e_q = '0; e_done = 0; e_act = 0;
      for (int i = 0; i < n; i++) begin
        if (m_xfer[i] <= k && k < m_apply[i]) occ++;
        if (m_apply[i] == k) begin
          prev = (i > 0) ? m_tgt[i-1] : '0;
          e_s  = m_tgt[i] & ~prev;
          e_r  = ~m_tgt[i] & prev;
        end
        if (m_apply[i] < k) e_q = m_tgt[i];
        if (m_fin[i] == k) e_done = 1;
        if (m_apply[i] <= k && k <= m_fin[i]) e_act = 1;
      end
      check("rnd_s", s, e_s);
      check("rnd_r", r, e_r);
      check("rnd_q", q_model, e_q);
      check("rnd_ready", in_ready, (occ < DEPTH));
      check("rnd_busy", busy, (e_act || occ > 0));
      check("rnd_done", word_done, e_done);
      check("rnd_s_and_r", s & r, 0);
      if (n < max_words && $urandom_range(99) < valid_pct) begin
        h         = $urandom_range(hmax, hmin);
        in_valid  = 1'b1;
        in_target = W'($urandom);
        in_hold   = HW'(h);
        if (occ < DEPTH) begin
          m_xfer[n]  = k + 1;
          m_apply[n] = (k + 2 > last_fin + 1) ? k + 2 : last_fin + 1;
          m_fin[n]   = m_apply[n] + h;
          m_tgt[n]   = in_target;
          last_fin   = m_fin[n];
          n++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("rnd_all_words_done", (last_fin < ncycles), 1);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs [7];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_target = '0; in_hold = '0;
    vecs[0] = '{tgt: 4'b0101, hold: 4'd0,  exp_s: 4'b0101, exp_r: 4'b0000};
    vecs[1] = '{tgt: 4'b0011, hold: 4'd0,  exp_s: 4'b0010, exp_r: 4'b0100};
    vecs[2] = '{tgt: 4'b0011, hold: 4'd0,  exp_s: 4'b0000, exp_r: 4'b0000};
    vecs[3] = '{tgt: 4'b1111, hold: 4'd3,  exp_s: 4'b1100, exp_r: 4'b0000};
    vecs[4] = '{tgt: 4'b0000, hold: 4'd0,  exp_s: 4'b0000, exp_r: 4'b1111};
    vecs[5] = '{tgt: 4'b1010, hold: 4'd1,  exp_s: 4'b1010, exp_r: 4'b0000};
    vecs[6] = '{tgt: 4'b0110, hold: 4'd15, exp_s: 4'b0100, exp_r: 4'b1000};

    // Reset with in_valid high: nothing may be stored.
    do_reset(1'b1, 4'b1111);
    check("rst_s", s, 0);
    check("rst_r", r, 0);
    check("rst_q", q_model, 0);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", word_done, 0);
    repeat (4) begin
      @(negedge clk);
      check("rst_no_word", {s, r, busy}, 0);
    end

    for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

    // Back-to-back 0101 then 0011, hold=0.
    do_reset(1'b0, '0);
    in_valid = 1'b1; in_target = 4'b0101; in_hold = '0;
    @(posedge clk);
    @(negedge clk);
    in_target = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_s0", s, 4'b0101);
    check("b2b_r0", r, 4'b0000);
    check("b2b_done0", word_done, 1);
    @(negedge clk);
    check("b2b_s1", s, 4'b0010);
    check("b2b_r1", r, 4'b0100);
    check("b2b_done1", word_done, 1);
    @(negedge clk);
    check("b2b_q", q_model, 4'b0011);
    check("b2b_idle_sr", {s, r}, 0);
    check("b2b_busy", busy, 0);

    // Reset in the middle of a HOLD with two words queued behind it.
    do_reset(1'b0, '0);
    in_valid = 1'b1; in_target = 4'b1111; in_hold = 4'd6;
    @(posedge clk); @(negedge clk);
    in_target = 4'b0001; in_hold = 4'd0;
    @(posedge clk); @(negedge clk);
    in_target = 4'b0010;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("mid_in_hold_sr", {s, r}, 0);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("mid_rst_sr", {s, r}, 0);
    check("mid_rst_q", q_model, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 1);
    repeat (10) begin
      @(negedge clk);
      check("mid_no_apply", {s, r, word_done, busy}, 0);
    end

    // Randomized traffic, backpressure burst, long holds.
    do_reset(1'b0, '0);
    run_model(400, 60, 0, 3, 60);
    do_reset(1'b0, '0);
    run_model(80, 100, 5, 5, 6);
    do_reset(1'b0, '0);
    run_model(450, 30, 0, 15, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
